// File: rtl/controle_acumulador_pkg.sv
// controle_acumulador_pkg
// Shared definitions for the accumulator sequencer:
//   - default widths for address, data word and word count
//   - 3-bit binary state encoding (IDLE = 0)
//   - strobe bundle and the function that maps a state onto the strobes
//     that must be visible while the FSM sits in that state
package controle_acumulador_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 9;   // must hold 2**ADDR_W_DEF

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_READ = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_LOAD = 3'd4;
    localparam logic [2:0] ST_XFER = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef struct packed {
        logic mem_rd;
        logic load;
        logic clear;
        logic transfer;
        logic busy;
        logic done;
    } strobes_t;

    // Strobe values that belong to a state. The FSM registers these from the
    // next state, so every strobe comes straight out of a flop.
    function automatic strobes_t strobes_for(input logic [2:0] st);
        strobes_t s;
        s      = '0;
        s.busy = (st != ST_IDLE);
        case (st)
            ST_CLR:  s.clear    = 1'b1;
            ST_READ: s.mem_rd   = 1'b1;
            ST_LOAD: s.load     = 1'b1;
            ST_XFER: s.transfer = 1'b1;
            ST_DONE: s.done     = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controle_acumulador_if.sv
// controle_acumulador_if
// Bundles the sequencer's request, memory and accumulator signals.
//   start, base_addr, count : run request (driven by the host)
//   mem_addr, mem_rd        : synchronous memory read port (driven by sequencer)
//   mem_data                : memory read data, valid one cycle after mem_rd
//   data_out                : word presented to the accumulator data input
//   load, clear, transfer   : accumulator register strobes
//   busy, done              : run status
// master = sequencer side, slave = host/memory/accumulator side.
interface controle_acumulador_if
    import controle_acumulador_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] data_out;
    logic              load;
    logic              clear;
    logic              transfer;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, count, mem_data,
        output mem_addr, mem_rd, data_out, load, clear, transfer, busy, done
    );

    modport slave (
        output start, base_addr, count, mem_data,
        input  mem_addr, mem_rd, data_out, load, clear, transfer, busy, done
    );

endinterface

// File: rtl/controle_acumulador_contador_palavras.sv
// contador_palavras
// Word address and remaining-count registers for the sequencer.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture base_addr/count at the start of a run
//   step      : advance to the next word (addr+1 with wrap, rem-1)
//   base_addr : first address of the run
//   count     : number of words in the run
//   addr      : current word address
//   last      : exactly one word remains
//   zero      : no words remain
module contador_palavras
    import controle_acumulador_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              zero
);

    logic [CNT_W-1:0] rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            rem  <= '0;
        end else if (load) begin
            addr <= base_addr;
            rem  <= count;
        end else if (step) begin
            // Address wraps naturally at 2**ADDR_W, so counts larger than the
            // memory simply re-read from the bottom.
            addr <= addr + 1'b1;
            rem  <= rem - 1'b1;
        end
    end

    assign last = (rem == CNT_W'(1));
    assign zero = (rem == '0);

endmodule

// File: rtl/controle_acumulador.sv
// controle_acumulador
// Sequencer in front of the Acumulador datapath. On an accepted start it
// clears the accumulator, then for each of count words starting at base_addr
// it reads memory, presents the word on data_out, pulses load and then
// transfer, and finally pulses done.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, overrides everything
//   bus  : controle_acumulador_if.master (request, memory port, accumulator
//          strobes, status)
// load, clear and transfer act as register clocks inside the accumulator, so
// every output is a flop loaded from a decode of the next state.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | clear pulse to the accumulator
// READ  | memory read strobe at the current address
// WAIT  | memory data arrives, captured into data_out at end of cycle
// LOAD  | load pulse, accumulator register B takes data_out
// XFER  | transfer pulse, A <= A+B; advance address, decrement remaining
// DONE  | completion pulse
module controle_acumulador
    import controle_acumulador_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    controle_acumulador_if.master bus
);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    strobes_t          strb_nx;

    logic              cnt_load;
    logic              cnt_step;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              last;
    logic              zero;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] data_q;
    logic              mem_rd_q;
    logic              load_q;
    logic              clear_q;
    logic              transfer_q;
    logic              busy_q;
    logic              done_q;

    assign cnt_load = (state == ST_IDLE) && bus.start;
    assign cnt_step = (state == ST_XFER);
    assign addr_inc = addr + 1'b1;

    contador_palavras #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_contador (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .step      (cnt_step),
        .base_addr (bus.base_addr),
        .count     (bus.count),
        .addr      (addr),
        .last      (last),
        .zero      (zero)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_CLR;
            ST_CLR:  state_nx = zero ? ST_DONE : ST_READ;
            ST_READ: state_nx = ST_WAIT;
            ST_WAIT: state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_XFER;
            ST_XFER: state_nx = last ? ST_DONE : ST_READ;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign strb_nx = strobes_for(state_nx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mem_addr_q <= '0;
            data_q     <= '0;
            mem_rd_q   <= 1'b0;
            load_q     <= 1'b0;
            clear_q    <= 1'b0;
            transfer_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            mem_rd_q   <= strb_nx.mem_rd;
            load_q     <= strb_nx.load;
            clear_q    <= strb_nx.clear;
            transfer_q <= strb_nx.transfer;
            busy_q     <= strb_nx.busy;
            done_q     <= strb_nx.done;
            // Leaving XFER the counter advances on this same edge, so the
            // read address for the next word is taken one ahead.
            if (state_nx == ST_READ) begin
                mem_addr_q <= (state == ST_XFER) ? addr_inc : addr;
            end
            // Memory data is valid during WAIT; data_out keeps it until the
            // next word, and across runs.
            if (state == ST_WAIT) begin
                data_q <= bus.mem_data;
            end
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.data_out = data_q;
    assign bus.load     = load_q;
    assign bus.clear    = clear_q;
    assign bus.transfer = transfer_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
